// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator for the byte-addressed 16-bit data memory.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned word accesses into two byte accesses.
module load_store_unit #(
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [1:0]  reqSize,
    input  logic [15:0] reqAddr,
    input  logic [15:0] reqData,
    output logic        respValid,
    output logic [15:0] respData,
    output logic        respErr,
    output logic        busy,
    output logic        memWrEnable,
    output logic        memRdEnable,
    output logic [1:0]  memNumberOfByte,
    output logic [15:0] memAddress,
    output logic [15:0] memIn,
    input  logic [15:0] memOut
);

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [CW-1:0] WAIT_INIT = CW'(RD_LATENCY - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ISSUE_HI, WAIT_HI, RESP} state_t;

    state_t        state;
    logic          latWrite;
    logic          latErr;
    logic          latSplit;
    logic [15:0]   latAddr;
    logic [7:0]    latDataHi;
    logic [7:0]    loByte;
    logic [CW-1:0] waitCnt;

    logic misaligned;
    logic reqSplit;
    logic reqErr;

    assign misaligned = (reqSize == 2'b00) && reqAddr[0];
    assign reqSplit   = SPLIT_EN && misaligned;
    assign reqErr     = (reqSize == 2'b11) || (misaligned && !SPLIT_EN);

    // Every output is registered, so each transition also loads the values the next state presents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            reqReady        <= 1'b1;
            respValid       <= 1'b0;
            respData        <= 16'h0000;
            respErr         <= 1'b0;
            busy            <= 1'b0;
            memWrEnable     <= 1'b0;
            memRdEnable     <= 1'b0;
            memNumberOfByte <= 2'b00;
            memAddress      <= 16'h0000;
            memIn           <= 16'h0000;
            latWrite        <= 1'b0;
            latErr          <= 1'b0;
            latSplit        <= 1'b0;
            latAddr         <= 16'h0000;
            latDataHi       <= 8'h00;
            loByte          <= 8'h00;
            waitCnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (reqValid && reqReady) begin
                        state     <= ISSUE;
                        reqReady  <= 1'b0;
                        busy      <= 1'b1;
                        latWrite  <= reqWrite;
                        latErr    <= reqErr;
                        latSplit  <= reqSplit;
                        latAddr   <= reqAddr;
                        latDataHi <= reqData[15:8];
                        if (!reqErr) begin
                            memAddress <= reqAddr;
                            if (reqWrite) begin
                                memWrEnable     <= 1'b1;
                                memIn           <= reqSplit ? {8'h00, reqData[7:0]} : reqData;
                                memNumberOfByte <= (reqSize == 2'b00 && !reqSplit) ? 2'b10 : 2'b00;
                            end else begin
                                memRdEnable     <= 1'b1;
                                memNumberOfByte <= reqSplit ? 2'b01 : reqSize;
                            end
                        end
                    end
                end
                ISSUE: begin
                    memWrEnable <= 1'b0;
                    memRdEnable <= 1'b0;
                    if (latErr) begin
                        state     <= RESP;
                        respValid <= 1'b1;
                        respErr   <= 1'b1;
                        respData  <= 16'h0000;
                    end else if (latWrite) begin
                        if (latSplit) begin
                            state           <= ISSUE_HI;
                            memWrEnable     <= 1'b1;
                            memAddress      <= latAddr + 16'd1;
                            memIn           <= {8'h00, latDataHi};
                            memNumberOfByte <= 2'b00;
                        end else begin
                            state     <= RESP;
                            respValid <= 1'b1;
                        end
                    end else begin
                        state   <= WAIT;
                        waitCnt <= WAIT_INIT;
                    end
                end
                WAIT: begin
                    if (waitCnt == '0) begin
                        if (latSplit) begin
                            state           <= ISSUE_HI;
                            loByte          <= memOut[7:0];
                            memRdEnable     <= 1'b1;
                            memAddress      <= latAddr + 16'd1;
                            memNumberOfByte <= 2'b01;
                        end else begin
                            state     <= RESP;
                            respValid <= 1'b1;
                            respData  <= memOut;
                        end
                    end else begin
                        waitCnt <= waitCnt - CW'(1);
                    end
                end
                ISSUE_HI: begin
                    memWrEnable <= 1'b0;
                    memRdEnable <= 1'b0;
                    if (latWrite) begin
                        state     <= RESP;
                        respValid <= 1'b1;
                    end else begin
                        state   <= WAIT_HI;
                        waitCnt <= WAIT_INIT;
                    end
                end
                WAIT_HI: begin
                    if (waitCnt == '0) begin
                        state     <= RESP;
                        respValid <= 1'b1;
                        respData  <= {memOut[7:0], loByte};
                    end else begin
                        waitCnt <= waitCnt - CW'(1);
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    respValid <= 1'b0;
                    respErr   <= 1'b0;
                    respData  <= 16'h0000;
                    busy      <= 1'b0;
                    reqReady  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a byte-array memory model (RD_LATENCY = 1).
// Build with LSU_MISALIGN_SPLIT_EN defined to check the split-access variant.
module tb_load_store_unit;

    localparam int RD_LATENCY = 1;

    logic        clk;
    logic        reset;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [1:0]  reqSize;
    logic [15:0] reqAddr;
    logic [15:0] reqData;
    logic        respValid;
    logic [15:0] respData;
    logic        respErr;
    logic        busy;
    logic        memWrEnable;
    logic        memRdEnable;
    logic [1:0]  memNumberOfByte;
    logic [15:0] memAddress;
    logic [15:0] memIn;
    logic [15:0] memOut;

    logic [7:0] mem [0:65535];
    int testCount = 0;
    int failCount = 0;
    int wrCount = 0;
    int rdCount = 0;
    int respCount = 0;

    int          respCycle;
    logic [15:0] gotData;
    logic        gotErr;
    logic        issueWr;
    logic        issueRd;
    logic [1:0]  issueNb;

    load_store_unit #(.RD_LATENCY(RD_LATENCY)) dut (
        .clk(clk), .reset(reset),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
        .reqSize(reqSize), .reqAddr(reqAddr), .reqData(reqData),
        .respValid(respValid), .respData(respData), .respErr(respErr), .busy(busy),
        .memWrEnable(memWrEnable), .memRdEnable(memRdEnable),
        .memNumberOfByte(memNumberOfByte), .memAddress(memAddress),
        .memIn(memIn), .memOut(memOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] memRead(input logic [15:0] a, input logic [1:0] nb);
        logic [15:0] a1;
        a1 = a + 16'd1;
        case (nb)
            2'b00:   return {mem[a1], mem[a]};
            2'b01:   return {8'h00, mem[a]};
            2'b10:   return {{8{mem[a][7]}}, mem[a]};
            default: return 16'h0000;
        endcase
    endfunction

    // Memory model: little-endian words, read data appears one edge after the read strobe.
    always @(posedge clk) begin
        logic [15:0] a1;
        a1 = memAddress + 16'd1;
        if (reset) begin
            if (memWrEnable) begin
                wrCount++;
                mem[memAddress] = memIn[7:0];
                if (memNumberOfByte == 2'b10) mem[a1] = memIn[15:8];
            end
            if (memRdEnable) begin
                rdCount++;
                memOut <= memRead(memAddress, memNumberOfByte);
            end
            if (respValid) respCount++;
        end
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One request, accepted on the first edge; records the cycle of respValid and the ISSUE-cycle strobes.
    task automatic applyStimulus(input logic write, input logic [1:0] size,
                                 input logic [15:0] addr, input logic [15:0] data);
        int n;
        @(negedge clk);
        reqValid = 1'b1;
        reqWrite = write;
        reqSize  = size;
        reqAddr  = addr;
        reqData  = data;
        @(posedge clk);
        #1 reqValid = 1'b0;
        n = 0;
        respCycle = 0;
        gotData = 16'hxxxx;
        gotErr = 1'bx;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                issueWr = memWrEnable;
                issueRd = memRdEnable;
                issueNb = memNumberOfByte;
            end
            if (respValid) begin
                respCycle = n;
                gotData = respData;
                gotErr = respErr;
                break;
            end
        end
        if (respCycle == 0) checkOutput("respTimeout", {15'd0, respValid}, 16'd1);
    endtask

    initial begin
        int wr0, rd0, rs0, accepts, readyViol;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        memOut = 16'h0000;
        reset = 1'b0;
        reqValid = 1'b0;
        reqWrite = 1'b0;
        reqSize = 2'b00;
        reqAddr = 16'h0000;
        reqData = 16'h0000;
        repeat (3) @(negedge clk);

        checkOutput("rstReqReady", {15'd0, reqReady}, 16'd1);
        checkOutput("rstBusy", {15'd0, busy}, 16'd0);
        checkOutput("rstRespValid", {15'd0, respValid}, 16'd0);
        checkOutput("rstWrEn", {15'd0, memWrEnable}, 16'd0);
        checkOutput("rstRdEn", {15'd0, memRdEnable}, 16'd0);
        checkOutput("rstAddr", memAddress, 16'h0000);
        reset = 1'b1;
        @(negedge clk);

        // Word store then word load at 0x0010
        applyStimulus(1'b1, 2'b00, 16'h0010, 16'h1234);
        checkOutput("stWordCycle", 16'(respCycle), 16'd2);
        checkOutput("stWordErr", {15'd0, gotErr}, 16'd0);
        checkOutput("stWordStrobe", {15'd0, issueWr}, 16'd1);
        checkOutput("stWordNb", {14'd0, issueNb}, 16'd2);
        checkOutput("stWordMem", {mem[16'h0011], mem[16'h0010]}, 16'h1234);
        applyStimulus(1'b0, 2'b00, 16'h0010, 16'h0000);
        checkOutput("ldWordCycle", 16'(respCycle), 16'(RD_LATENCY + 2));
        checkOutput("ldWordData", gotData, 16'h1234);
        checkOutput("ldWordErr", {15'd0, gotErr}, 16'd0);
        checkOutput("ldWordStrobe", {15'd0, issueRd}, 16'd1);

        // Byte loads: zero- and sign-extension done by the memory
        mem[16'h0020] = 8'h85;
        applyStimulus(1'b0, 2'b01, 16'h0020, 16'h0000);
        checkOutput("ldByteZext", gotData, 16'h0085);
        checkOutput("ldByteZextNb", {14'd0, issueNb}, 16'd1);
        applyStimulus(1'b0, 2'b10, 16'h0020, 16'h0000);
        checkOutput("ldByteSext", gotData, 16'hFF85);

        // Reserved size: no memory access, error response in cycle 2
        wr0 = wrCount; rd0 = rdCount;
        applyStimulus(1'b0, 2'b11, 16'h0004, 16'h0000);
        checkOutput("rsvdCycle", 16'(respCycle), 16'd2);
        checkOutput("rsvdErr", {15'd0, gotErr}, 16'd1);
        checkOutput("rsvdData", gotData, 16'h0000);
        checkOutput("rsvdStrobes", 16'(wrCount - wr0 + rdCount - rd0), 16'd0);

        // Misaligned word at 0xFFFF
        wr0 = wrCount; rd0 = rdCount;
        applyStimulus(1'b1, 2'b00, 16'hFFFF, 16'hBEEF);
`ifdef LSU_MISALIGN_SPLIT_EN
        checkOutput("misStCycle", 16'(respCycle), 16'd3);
        checkOutput("misStErr", {15'd0, gotErr}, 16'd0);
        checkOutput("misStLo", {8'h00, mem[16'hFFFF]}, 16'h00EF);
        checkOutput("misStHi", {8'h00, mem[16'h0000]}, 16'h00BE);
        checkOutput("misStPulses", 16'(wrCount - wr0), 16'd2);
        applyStimulus(1'b0, 2'b00, 16'hFFFF, 16'h0000);
        checkOutput("misLdCycle", 16'(respCycle), 16'(2 * RD_LATENCY + 3));
        checkOutput("misLdData", gotData, 16'hBEEF);
        checkOutput("misLdErr", {15'd0, gotErr}, 16'd0);
        checkOutput("misLdPulses", 16'(rdCount - rd0), 16'd2);
`else
        checkOutput("misStErr", {15'd0, gotErr}, 16'd1);
        checkOutput("misStCycle", 16'(respCycle), 16'd2);
        checkOutput("misStMem", {mem[16'h0000], mem[16'hFFFF]}, 16'h0000);
        applyStimulus(1'b0, 2'b00, 16'hFFFF, 16'h0000);
        checkOutput("misLdErr", {15'd0, gotErr}, 16'd1);
        checkOutput("misLdData", gotData, 16'h0000);
        checkOutput("misStrobes", 16'(wrCount - wr0 + rdCount - rd0), 16'd0);
`endif

        // reqValid held high across three stores
        @(negedge clk);
        wr0 = wrCount; rs0 = respCount; accepts = 0; readyViol = 0;
        reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'b00;
        reqAddr = 16'h0040; reqData = 16'h1357;
        for (int c = 0; c < 30; c++) begin
            if (busy === reqReady) readyViol++;
            if (reqReady) accepts++;
            if (accepts == 3) break;
            @(negedge clk);
        end
        @(posedge clk);
        #1 reqValid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (busy === reqReady) readyViol++;
        end
        checkOutput("b2bAccepts", 16'(accepts), 16'd3);
        checkOutput("b2bWrPulses", 16'(wrCount - wr0), 16'd3);
        checkOutput("b2bRespPulses", 16'(respCount - rs0), 16'd3);
        checkOutput("b2bBusyReady", 16'(readyViol), 16'd0);
        checkOutput("b2bMem", {mem[16'h0041], mem[16'h0040]}, 16'h1357);

        // Reset while a load waits on the memory
        @(negedge clk);
        reqValid = 1'b1; reqWrite = 1'b0; reqSize = 2'b00; reqAddr = 16'h0010;
        @(posedge clk);
        #1 reqValid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        checkOutput("midRstRdEn", {15'd0, memRdEnable}, 16'd0);
        checkOutput("midRstBusy", {15'd0, busy}, 16'd0);
        checkOutput("midRstResp", {15'd0, respValid}, 16'd0);
        checkOutput("midRstReady", {15'd0, reqReady}, 16'd1);
        repeat (2) @(negedge clk);
        rs0 = respCount;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("midRstNoResp", 16'(respCount - rs0), 16'd0);
        applyStimulus(1'b0, 2'b00, 16'h0010, 16'h0000);
        checkOutput("postRstCycle", 16'(respCycle), 16'(RD_LATENCY + 2));
        checkOutput("postRstData", gotData, 16'h1234);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
